// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// bit-period helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Clocks per bit; integer division truncates, so the line rate rounds up slightly.
  function automatic int calc_bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while enabled and flags the
// terminal count with a one-cycle tick. Shared by the TX and RX paths.
module uart_baud_gen #(
  parameter int BIT_CYCLES = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en && w_last;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB-first with registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BIT_CYCLES = calc_bit_cycles(CLK_FREQ, BAUD);

  uart_state_e r_state;
  logic [7:0]  r_shreg;
  logic [2:0]  r_bit_idx;
  logic        r_tx_out;
  logic        r_busy;
  logic        r_done;
  logic        w_accept;
  logic        w_tick;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  assign w_accept = (r_state == IDLE) && tx_en && tx_start;

  uart_baud_gen #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_accept),
    .i_en    (r_state != IDLE),
    .o_tick  (w_tick)
  );

  // Reset is asynchronous so the line returns high at once, abandoning any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_tx_out  <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg   <= tx_data;
            r_bit_idx <= '0;
            r_tx_out  <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= START;
`ifdef UART_TX_PARITY_EN
            r_parity  <= ^tx_data;
`endif
          end
        end
        START: begin
          if (w_tick) begin
            r_tx_out <= r_shreg[0];
            r_state  <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_tx_out <= r_parity;
              r_state  <= PARITY;
`else
              r_tx_out <= 1'b1;
              r_state  <= STOP;
`endif
            end else begin
              // Present the next bit as the register shifts right.
              r_shreg   <= {1'b0, r_shreg[7:1]};
              r_tx_out  <= r_shreg[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_tx_out <= 1'b1;
            r_state  <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_tx_out <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign tx_out  = r_tx_out;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at BIT_CYCLES=10; follows the
// frame length of the build (UART_TX_PARITY_EN adds the parity slot).
module tb_uart_tx;

  localparam int BC = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_en = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  uart_tx #(
    .CLK_FREQ (1000),
    .BAUD     (100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_en    (tx_en),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hand-derived line level for bit slot b of a frame carrying byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9 && NB == 11) return ^d;
    return 1'b1;
  endfunction

  // Request a frame; returns #1 after the accepting edge (inside cycle 1).
  task automatic start_frame(input logic [7:0] d);
    @(posedge clk); #1;
    tx_en    = 1'b1;
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  // Checks every cycle of a frame and the tx_done cycle. mode 1 injects a
  // mid-frame request and drops tx_en; mode 2 scrambles tx_data each cycle.
  // If chain is set, the next request is raised inside the tx_done cycle.
  task automatic expect_frame(input logic [7:0] d, input int mode,
                              input bit chain, input logic [7:0] nd);
    for (int c = 1; c <= NB*BC; c++) begin
      @(negedge clk);
      check("bit", {24'd0, 8'(c), 7'd0, tx_out}, {24'd0, 8'(c), 7'd0, exp_bit(d, (c-1)/BC)});
      check("busy", {31'd0, tx_busy}, 32'd1);
      check("done_early", {31'd0, tx_done}, 32'd0);
      if (mode == 1 && c == 35) begin tx_data = 8'h3C; tx_start = 1'b1; end
      if (mode == 1 && c == 36) tx_start = 1'b0;
      if (mode == 1 && c == 50) tx_en = 1'b0;
      if (mode == 2) tx_data = 8'($urandom);
    end
    @(negedge clk);
    check("done", {31'd0, tx_done}, 32'd1);
    check("busy_end", {31'd0, tx_busy}, 32'd0);
    check("idle_line", {31'd0, tx_out}, 32'd1);
    if (chain) begin
      tx_en    = 1'b1;
      tx_data  = nd;
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
    end
  endtask

  task automatic expect_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, {29'd0, tx_out, tx_busy, tx_done}, 32'b100);
    end
  endtask

  initial begin
    #12;
    check("rst_out", {31'd0, tx_out}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    @(negedge clk); rst = 1'b1;
    expect_idle("idle0", 3);

    // Basic frame
    start_frame(8'hA5);
    expect_frame(8'hA5, 0, 1'b0, 8'h00);
    expect_idle("post_a5", 5);

    // Back-to-back: second request raised in the tx_done cycle
    start_frame(8'h00);
    expect_frame(8'h00, 0, 1'b1, 8'hFF);
    expect_frame(8'hFF, 0, 1'b0, 8'h00);
    expect_idle("post_b2b", 5);

    // Ignored requests: mid-frame start, tx_en dropped, start while disabled
    start_frame(8'h81);
    expect_frame(8'h81, 1, 1'b0, 8'h00);
    @(negedge clk); tx_data = 8'h3C; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    expect_idle("ignored", 30);

    // Reset during data bit 3 (slot 4, cycles 41..50)
    start_frame(8'hF0);
    repeat (45) @(negedge clk);
    check("pre_rst_bit", {31'd0, tx_out}, 32'd0);
    check("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_out", {31'd0, tx_out}, 32'd1);
    check("async_busy", {31'd0, tx_busy}, 32'd0);
    expect_idle("in_rst", 2);
    rst = 1'b1;
    expect_idle("after_rst", 12);
    start_frame(8'h55);
    expect_frame(8'h55, 0, 1'b0, 8'h00);

    // Parity slot values (0x07 -> 1, 0x03 -> 0 with parity built)
    start_frame(8'h07);
    expect_frame(8'h07, 0, 1'b0, 8'h00);
    start_frame(8'h03);
    expect_frame(8'h03, 0, 1'b0, 8'h00);

    // Data stability while busy
    start_frame(8'hC3);
    expect_frame(8'hC3, 2, 1'b0, 8'h00);
    expect_idle("post_c3", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter, the transmit-side counterpart of the project's UART receiver.
- Serialises one byte per request as 8N1: start bit (0), 8 data bits LSB-first, stop bit (1). An optional even-parity bit sits between data and stop.
- Contains its own bit-period counter, so it needs no external baud module.
- Driven by the music/control logic to send status or echo bytes to the host.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- BIT_CYCLES (localparam) = CLK_FREQ/BAUD using integer division. Must be >= 2. Default is 5208.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- tx_en  input  1  module enable. When low, new requests are ignored; a frame already in progress completes.
- tx_start  input  1  request pulse. Sampled only in IDLE.
- tx_data  input  8  byte to send. Captured on the accepted tx_start cycle.
- tx_out  output  1  serial line, idles high.
- tx_busy  output  1  high while a frame is in flight.
- tx_done  output  1  one-cycle pulse on frame completion.

Behaviour:
- Reset (async, rst low): state=IDLE, tx_out=1, tx_busy=0, tx_done=0, shift register=0, counters=0. This applies mid-frame too: the line returns high immediately and the partial frame is abandoned.
- States: IDLE, START, DATA, PARITY (only with the feature), STOP.
- IDLE:
  - tx_done is high only on the first IDLE cycle after STOP; otherwise 0.
  - If tx_en && tx_start: latch tx_data into the shift register, clear the bit counter and bit-period counter, go to START.
  - tx_start while tx_en=0 is dropped, not queued.
- Registered outputs: tx_out and tx_busy change on the clock edge after acceptance. tx_out=0 from the cycle after the accepted start.
- Bit-period counter:
  - Counts 0..BIT_CYCLES-1, and each state holds the line for exactly BIT_CYCLES clocks.
  - The terminal count advances the state and resets the counter to 0.
- START: tx_out=0 for BIT_CYCLES, then go to DATA.
- DATA:
  - tx_out = shreg[0] at each bit start. The register shifts right on each terminal count.
  - A 3-bit index counts 0..7. After index 7 terminates, go to STOP (or PARITY).
- PARITY: tx_out = XOR of the latched byte (even parity), for BIT_CYCLES.
- STOP: tx_out=1 for BIT_CYCLES. At terminal count go to IDLE and set tx_done=1 for one cycle.
- tx_busy: 1 in START/DATA/PARITY/STOP, 0 in IDLE.
- Frame length from accept to tx_done is 10*BIT_CYCLES+1 clocks (11*BIT_CYCLES+1 with parity).
- tx_start is legal in the tx_done cycle and is accepted, giving back-to-back frames with no idle gap beyond the stop bit.
- tx_start/tx_data changes while busy are ignored. The byte being sent is the latched copy.
- tx_en dropping mid-frame has no effect on the current frame.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted after DATA and sends even parity over the 8 data bits, giving an 11-bit frame. This matches the receiver's parity slot.
- Undefined: no PARITY state, the frame is 10 bits, and the parity XOR logic is not built.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit);
  - DATA_BITS=8;
  - a function computing BIT_CYCLES from CLK_FREQ/BAUD. The receiver reuses this.
- Sub-module uart_baud_gen:
  - inputs: the bit-period counter with clear/enable;
  - output: a one-cycle tick at terminal count;
  - parameter BIT_CYCLES;
  - shareable with the receiver path.

Test Plan:
- Basic frame: CLK_FREQ=1000, BAUD=100 (BIT_CYCLES=10), send 0xA5. tx_out sequence per 10-clock bit is 0,1,0,1,0,0,1,0,1,1. tx_done pulses at accept+101 clocks. tx_busy is high for 100 clocks.
- Back-to-back: send 0x00, then assert tx_start with 0xFF exactly in the tx_done cycle. The second start bit follows the first stop bit with no extra idle; the second frame is all-ones data.
- Ignored requests: pulse tx_start (0x3C) mid-frame of 0x81, and pulse tx_start with tx_en=0 in IDLE. Only 0x81 is transmitted; the line stays high afterwards; no extra tx_done.
- Reset mid-frame: assert rst low during data bit 3. tx_out=1 and tx_busy=0 asynchronously, no tx_done. After release, a new 0x55 frame is correct.
- Parity (UART_TX_PARITY_EN defined): 0x07 gives parity bit 1 and 0x03 gives parity bit 0. The frame is 110 clocks and tx_done is at +111.
- Data stability: change tx_data every cycle during a 0xC3 frame. The serialised bits remain those of 0xC3.
